// File: rtl/ni_initiator_route_sched.sv
// NI initiator request sequencer: registers a request address, drives the routing
// LUT, captures the route/target and issues an in-order header or a local decode error.
module ni_initiator_route_sched #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned PATH_WIDTH   = 7,
    parameter int unsigned TARGET_WIDTH = 4,
    parameter int unsigned MAX_OUTST    = 8,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [ADDR_WIDTH-1:0]   lut_address,
    input  logic [PATH_WIDTH-1:0]   lut_path,
    input  logic [TARGET_WIDTH-1:0] transaction_target,
    input  logic                    failed_decoding,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
    output logic [PATH_WIDTH-1:0]   hdr_path,
    output logic [TARGET_WIDTH-1:0] hdr_target,
    output logic                    err_valid,
    input  logic                    err_ready,
    input  logic                    rsp_done,
    output logic [CNT_WIDTH-1:0]    outstanding,
    output logic                    proto_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_ERR_WAIT = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTST);

    logic [2:0]              state;
    logic [2:0]              state_n;
    logic                    fail_q;
    logic [TARGET_WIDTH-1:0] cur_tgt;
    logic                    hdr_hs;
    logic                    err_hs;
    logic                    may_issue;

    assign hdr_hs = hdr_valid & hdr_ready;
    assign err_hs = err_valid & err_ready;

    // A header may go out when nothing is in flight, or when it continues the current target below the cap.
    assign may_issue = (outstanding == '0) ||
                       ((hdr_target == cur_tgt) && (outstanding < CNT_MAX));

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (req_valid && req_ready) state_n = S_LOOKUP;
            S_LOOKUP:   state_n = S_CHECK;
            S_CHECK: begin
                if (fail_q)         state_n = S_ERR_WAIT;
                else if (may_issue) state_n = S_ISSUE;
            end
            S_ISSUE:    if (hdr_hs) state_n = S_IDLE;
            S_ERR_WAIT: if (outstanding == '0) state_n = S_ERR;
            S_ERR:      if (err_hs) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // State, registered handshake outputs, captured LUT result and outstanding counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            hdr_valid   <= 1'b0;
            err_valid   <= 1'b0;
            lut_address <= '0;
            hdr_path    <= '0;
            hdr_target  <= '0;
            fail_q      <= 1'b0;
            cur_tgt     <= '0;
            outstanding <= '0;
            proto_err   <= 1'b0;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == S_IDLE);
            hdr_valid <= (state_n == S_ISSUE);
            err_valid <= (state_n == S_ERR);

            if ((state == S_IDLE) && req_valid) begin
                lut_address <= req_addr;
            end
            if (state == S_LOOKUP) begin
                hdr_path   <= lut_path;
                hdr_target <= transaction_target;
                fail_q     <= failed_decoding;
            end
            if (hdr_hs) begin
                cur_tgt <= hdr_target;
            end

            if (hdr_hs && !rsp_done) begin
                outstanding <= outstanding + CNT_WIDTH'(1);
            end else if (rsp_done && !hdr_hs) begin
                if (outstanding == '0) proto_err   <= 1'b1;
                else                   outstanding <= outstanding - CNT_WIDTH'(1);
            end
        end
    end

endmodule
